// File: rtl/render_dispatch.sv
// render_dispatch: issues frame pixels to LANES escape-time renderers and writes their results back; RENDER_DISPATCH_ABORT_EN adds iAbort.
module render_dispatch #(
  parameter int LANES = 4,
  parameter int COLS  = 640,
  parameter int ROWS  = 480,
  parameter int FXW   = 32,
  parameter int ITW   = 8
) (
  input  logic                 iCLK,
  input  logic                 iRST,
  input  logic                 iStart,
  input  logic [FXW-1:0]       iRe0,
  input  logic [FXW-1:0]       iIm0,
  input  logic [FXW-1:0]       iStep,
  output logic [LANES-1:0]     oLaneStart,
  output logic [FXW-1:0]       oLaneRe,
  output logic [FXW-1:0]       oLaneIm,
  input  logic [LANES-1:0]     iLaneDone,
  input  logic [LANES*ITW-1:0] iLaneIter,
  output logic                 oWrEn,
  output logic [19:0]          oWrAddr,
  output logic [ITW-1:0]       oWrData,
  input  logic                 iWrReady,
  output logic                 oBusy,
  output logic                 oFrameDone
`ifdef RENDER_DISPATCH_ABORT_EN
  ,
  input  logic                 iAbort
`endif
);
  localparam int LW = LANES > 1 ? $clog2(LANES) : 1;
  localparam int CW = COLS > 1 ? $clog2(COLS) : 1;
  localparam logic [19:0] LAST = 20'(COLS*ROWS-1);
  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;
  state_t state, state_n;
  logic [FXW-1:0] re0, step, cur_re, cur_im;
  logic [CW-1:0] col;
  logic [19:0] addr;
  logic [LANES-1:0] busy, pend;
  logic [19:0] tag [LANES];
  logic [ITW-1:0] res [LANES];
  logic [LW-1:0] gnt, cand, wl;
  logic gnt_ok, cand_ok, issue, accept, abort, wr_v, eol;
`ifdef RENDER_DISPATCH_ABORT_EN
  assign abort = iAbort && (state == ISSUE || state == DRAIN);
`else
  assign abort = 1'b0;
`endif
  // lowest free lane for issue; lowest pending lane not already on the write port
  always_comb begin
    gnt = '0;
    gnt_ok = 1'b0;
    cand = '0;
    cand_ok = 1'b0;
    for (int k = LANES-1; k >= 0; k--) begin
      if (!busy[k]) begin
        gnt = LW'(k);
        gnt_ok = 1'b1;
      end
      if (pend[k] && !(wr_v && wl == LW'(k))) begin
        cand = LW'(k);
        cand_ok = 1'b1;
      end
    end
  end
  assign issue      = state == ISSUE && gnt_ok && !abort;
  assign eol        = col == CW'(COLS-1);
  assign oLaneStart = issue ? LANES'(1) << gnt : '0;
  assign oLaneRe    = cur_re;
  assign oLaneIm    = cur_im;
  assign oWrEn      = wr_v && !abort;
  assign accept     = oWrEn && iWrReady;
  assign oBusy      = state == ISSUE || state == DRAIN;
  assign oFrameDone = state == DONE;
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = iStart ? ISSUE : IDLE;
      ISSUE:   state_n = abort ? IDLE : (issue && addr == LAST) ? DRAIN : ISSUE;
      DRAIN:   state_n = abort ? IDLE : (busy == '0 && pend == '0 && !wr_v) ? DONE : DRAIN;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state   <= IDLE;
      busy    <= '0;
      pend    <= '0;
      wr_v    <= 1'b0;
      wl      <= '0;
      oWrAddr <= '0;
      oWrData <= '0;
      re0     <= '0;
      step    <= '0;
      cur_re  <= '0;
      cur_im  <= '0;
      col     <= '0;
      addr    <= '0;
    end else begin
      state <= state_n;
      if (state == IDLE && iStart) begin
        re0    <= iRe0;
        step   <= iStep;
        cur_re <= iRe0;
        cur_im <= iIm0;
        col    <= '0;
        addr   <= '0;
      end
      if (issue) begin
        busy[gnt] <= 1'b1;
        addr      <= addr + 20'd1;
        col       <= eol ? '0 : col + 1'b1;
        cur_re    <= eol ? re0 : cur_re + step;
        cur_im    <= eol ? cur_im + step : cur_im;
      end
      for (int k = 0; k < LANES; k++)
        if (iLaneDone[k] && busy[k] && !pend[k]) pend[k] <= 1'b1;
      if (accept) begin
        busy[wl] <= 1'b0;
        pend[wl] <= 1'b0;
      end
      if (!wr_v || accept) begin
        wr_v <= cand_ok;
        if (cand_ok) begin
          wl      <= cand;
          oWrAddr <= tag[cand];
          oWrData <= res[cand];
        end
      end
      if (abort) begin
        busy <= '0;
        pend <= '0;
        wr_v <= 1'b0;
      end
    end
  end
  always_ff @(posedge iCLK) begin
    if (issue) tag[gnt] <= addr;
    for (int k = 0; k < LANES; k++)
      if (iLaneDone[k] && busy[k] && !pend[k]) res[k] <= iLaneIter[k*ITW +: ITW];
  end
endmodule

// File: tb/tb_render_dispatch.sv
// tb_render_dispatch: randomized frames checked against a pixel-level model of lanes, coordinates and writeback.
module tb_render_dispatch;
  localparam int LANES = 4, COLS = 4, ROWS = 3, ITW = 8, TOT = COLS*ROWS;
  logic iCLK = 1'b0, iRST = 1'b0, iStart = 1'b0, iWrReady = 1'b0;
  logic [31:0] iRe0 = '0, iIm0 = '0, iStep = '0;
  logic [LANES-1:0] iLaneDone = '0, oLaneStart;
  logic [LANES*ITW-1:0] iLaneIter = '0;
  logic [31:0] oLaneRe, oLaneIm;
  logic oWrEn, oBusy, oFrameDone;
  logic [19:0] oWrAddr;
  logic [ITW-1:0] oWrData;
`ifdef RENDER_DISPATCH_ABORT_EN
  logic iAbort = 1'b0;
`endif
  render_dispatch #(.LANES(LANES), .COLS(COLS), .ROWS(ROWS), .FXW(32), .ITW(ITW)) dut (
    .iCLK(iCLK), .iRST(iRST), .iStart(iStart), .iRe0(iRe0), .iIm0(iIm0), .iStep(iStep),
    .oLaneStart(oLaneStart), .oLaneRe(oLaneRe), .oLaneIm(oLaneIm),
    .iLaneDone(iLaneDone), .iLaneIter(iLaneIter),
    .oWrEn(oWrEn), .oWrAddr(oWrAddr), .oWrData(oWrData), .iWrReady(iWrReady),
    .oBusy(oBusy), .oFrameDone(oFrameDone)
`ifdef RENDER_DISPATCH_ABORT_EN
    , .iAbort(iAbort)
`endif
  );
  always #5 iCLK = ~iCLK;
  int tests = 0, fails = 0;
  int issued, written, done_cnt, cyc, mode, rdy_pct, low_n;
  bit frame, issuing, in_order, prev_hold;
  logic [19:0] prev_addr;
  logic [ITW-1:0] prev_data;
  logic [31:0] m_re0, m_im0, m_step;
  logic [ITW-1:0] exp_iter [TOT];
  bit wr_seen [TOT];
  int pix_lane [TOT];
  bit act [LANES], lbusy [LANES];
  int cnt [LANES], lpix [LANES], done_cyc [LANES];
  int w_lane [$], w_cyc [$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic void clear_model();
    issued = 0;
    written = 0;
    prev_hold = 0;
    for (int k = 0; k < LANES; k++) begin
      act[k] = 0;
      lbusy[k] = 0;
    end
    for (int p = 0; p < TOT; p++) wr_seen[p] = 0;
    w_lane.delete();
    w_cyc.delete();
  endfunction

  function automatic int nbusy();
    int n = 0;
    for (int k = 0; k < LANES; k++) n += int'(lbusy[k]);
    return n;
  endfunction

  // one clock: drive inputs #1 after the edge, sample #2 after it, update the model
  task automatic step(input bit start, input bit rst, input bit abrt, input logic [LANES-1:0] stray);
    logic [LANES-1:0] dn, exp_ls;
    logic [LANES*ITW-1:0] it;
    logic [31:0] e_re, e_im;
    int lo, l, a;
    bit all_act, rdy;
    @(posedge iCLK);
    #1;
    cyc++;
    dn = stray;
    it = '0;
    all_act = 1'b1;
    for (int k = 0; k < LANES; k++) if (!act[k]) all_act = 1'b0;
    for (int k = 0; k < LANES; k++)
      if (act[k]) begin
        if (mode == 2 ? (all_act || issued == TOT) : cnt[k] == 0) begin
          dn[k] = 1'b1;
          it[k*ITW +: ITW] = exp_iter[lpix[k]];
          act[k] = 1'b0;
          done_cyc[k] = cyc;
        end else cnt[k]--;
      end
    rdy = low_n > 0 ? 1'b0 : ($urandom_range(99) < rdy_pct);
    if (low_n > 0) low_n--;
    iLaneDone = dn;
    iLaneIter = it;
    iStart = start;
    iRST = rst;
    iWrReady = rdy;
`ifdef RENDER_DISPATCH_ABORT_EN
    iAbort = abrt;
`endif
    #1;
    lo = -1;
    for (int k = LANES-1; k >= 0; k--) if (!lbusy[k]) lo = k;
    exp_ls = '0;
    if (issuing && lo >= 0 && !abrt) exp_ls[lo] = 1'b1;
    chk("lane_start", oLaneStart, exp_ls);
    if (abrt) chk("abort_wren", oWrEn, 0);
    else begin
      if (exp_ls != '0) begin
        e_re = m_re0 + m_step * 32'(issued % COLS);
        e_im = m_im0 + m_step * 32'(issued / COLS);
        chk("lane_re", oLaneRe, e_re);
        chk("lane_im", oLaneIm, e_im);
        if (in_order && issued == 3) chk("px3_re", oLaneRe, 32'hE030_0000);
        lbusy[lo] = 1;
        act[lo] = 1;
        lpix[lo] = issued;
        pix_lane[issued] = lo;
        cnt[lo] = mode == 0 ? 2 : $urandom_range(0, 4);
        exp_iter[issued] = ITW'($urandom);
        issued++;
        if (issued == TOT) issuing = 0;
      end
      if (prev_hold) begin
        chk("hold_en", oWrEn, 1);
        chk("hold_addr", oWrAddr, prev_addr);
        chk("hold_data", oWrData, prev_data);
      end
      if (oWrEn && iWrReady) begin
        a = int'(oWrAddr);
        chk("wr_range", a < TOT, 1);
        if (a < TOT) begin
          l = pix_lane[a];
          chk("wr_dup", wr_seen[a], 0);
          chk("wr_tag", lpix[l], a);
          chk("wr_after_done", {lbusy[l], act[l], done_cyc[l] < cyc}, 3'b101);
          chk("wr_data", oWrData, exp_iter[a]);
          if (in_order) chk("wr_order", a, written);
          wr_seen[a] = 1;
          lbusy[l] = 0;
          written++;
          if (mode == 2) begin
            w_lane.push_back(l);
            w_cyc.push_back(cyc);
          end
        end
      end
    end
    prev_hold = oWrEn && !iWrReady;
    prev_addr = oWrAddr;
    prev_data = oWrData;
    if (!frame) chk("idle_busy", oBusy, 0);
    else if (written < TOT) chk("busy", oBusy, 1);
    if (oFrameDone) begin
      chk("done_in_frame", frame, 1);
      chk("done_all", written, TOT);
      chk("done_busy", oBusy, 0);
      done_cnt++;
      frame = 0;
    end
    if (start && !frame) begin
      clear_model();
      m_re0 = iRe0;
      m_im0 = iIm0;
      m_step = iStep;
      frame = 1;
      issuing = 1;
    end
    if (rst || abrt) begin
      clear_model();
      frame = 0;
      issuing = 0;
    end
  endtask

  task automatic run_frame(input logic [31:0] re0, input logic [31:0] im0, input logic [31:0] st,
                           input int md, input int rp, input bit poke);
    int d0;
    bit poked;
    iRe0 = re0;
    iIm0 = im0;
    iStep = st;
    mode = md;
    rdy_pct = rp;
    in_order = md == 0 && rp == 100;
    d0 = done_cnt;
    poked = 0;
    step(1, 0, 0, '0);
    for (int i = 0; i < 1000 && done_cnt == d0; i++) begin
      if (poke && !poked && issued == 3) begin
        iRe0 = $urandom;
        iIm0 = $urandom;
        iStep = $urandom;
        poked = 1;
        step(1, 0, 0, '0);
      end else step(0, 0, 0, '0);
    end
    chk("frame_done", done_cnt, d0 + 1);
    chk("frame_written", written, TOT);
    repeat (3) step(0, 0, 0, '0);
    chk("frame_done_once", done_cnt, d0 + 1);
  endtask

  initial begin
    clear_model();
    done_cnt = 0;
    cyc = 0;
    mode = 1;
    rdy_pct = 100;
    low_n = 0;
    frame = 0;
    issuing = 0;
    in_order = 0;
    step(0, 1, 0, '0);
    step(0, 1, 0, '0);
    step(0, 0, 0, '0);
    chk("rst_lane_start", oLaneStart, 0);
    chk("rst_wren", oWrEn, 0);
    chk("rst_busy", oBusy, 0);
    chk("rst_frame_done", oFrameDone, 0);
    chk("rst_wr_addr", oWrAddr, 0);
    chk("rst_wr_data", oWrData, 0);
    chk("rst_lane_re", oLaneRe, 0);
    chk("rst_lane_im", oLaneIm, 0);
    run_frame(32'hE000_0000, 32'hF000_0000, 32'h0010_0000, 0, 100, 0);
    run_frame($urandom, $urandom, $urandom, 1, 60, 1);
    low_n = 14;
    run_frame($urandom, $urandom, $urandom, 1, 100, 0);
    run_frame($urandom, $urandom, $urandom, 2, 100, 0);
    chk("sync_count", w_lane.size(), TOT);
    for (int i = 0; i < w_lane.size(); i++) begin
      chk("sync_lane", w_lane[i], i % LANES);
      if (i % LANES != 0) chk("sync_consec", w_cyc[i], w_cyc[i-1] + 1);
    end
    step(0, 0, 0, 4'b0100);
    repeat (3) begin
      step(0, 0, 0, '0);
      chk("stray_wr", oWrEn, 0);
    end
    iRe0 = $urandom;
    iIm0 = $urandom;
    iStep = $urandom;
    mode = 1;
    rdy_pct = 100;
    in_order = 0;
    step(1, 0, 0, '0);
    for (int i = 0; i < 100 && nbusy() < 3; i++) step(0, 0, 0, '0);
    chk("rst_mid_lanes", nbusy() >= 3, 1);
    step(0, 1, 0, '0);
    step(0, 0, 0, '0);
    chk("rst_mid_busy", oBusy, 0);
    chk("rst_mid_wren", oWrEn, 0);
    run_frame($urandom, $urandom, $urandom, 1, 80, 0);
`ifdef RENDER_DISPATCH_ABORT_EN
    begin
      int d0;
      d0 = done_cnt;
      iRe0 = $urandom;
      iIm0 = $urandom;
      iStep = $urandom;
      mode = 1;
      rdy_pct = 100;
      in_order = 0;
      step(1, 0, 0, '0);
      for (int i = 0; i < 100 && issued < 5; i++) step(0, 0, 0, '0);
      chk("abort_at_px5", issued, 5);
      step(0, 0, 1, '0);
      step(0, 0, 0, '0);
      chk("abort_busy", oBusy, 0);
      step(0, 0, 0, 4'b0001);
      repeat (3) begin
        step(0, 0, 0, '0);
        chk("abort_late_wr", oWrEn, 0);
      end
      chk("abort_no_done", done_cnt, d0);
      run_frame($urandom, $urandom, $urandom, 1, 70, 0);
    end
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
